muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_core.sv | 60 ++++++
 rtl/muldiv_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the ALU decoder.
// Controller FSM states, ALU opcodes for MULT/DIV, and an opcode-valid helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: one shift-add multiply step or one restoring divide step per cycle.
// The {p_hi, p_lo} pair is the product accumulator for MULT and {remainder, quotient} for DIV.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] p_hi_reg, p_hi_next;
    logic [WIDTH-1:0] p_lo_reg, p_lo_next;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, p_hi_reg} + (p_lo_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        div_shift = {p_hi_reg, p_lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        // The partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
        div_diff  = div_shift[WIDTH-1:0] - b_reg;
        if (op_div) begin
            p_hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
            p_lo_next = {p_lo_reg[WIDTH-2:0], div_ge};
        end else begin
            p_hi_next = mul_sum[WIDTH:1];
            p_lo_next = {mul_sum[0], p_lo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_hi_reg <= '0;
            p_lo_reg <= '0;
            b_reg    <= '0;
        end else if (load) begin
            p_hi_reg <= '0;
            p_lo_reg <= a;
            b_reg    <= b;
        end else if (step) begin
            p_hi_reg <= p_hi_next;
            p_lo_reg <= p_lo_next;
        end
    end

    assign res_hi = p_hi_reg;
    assign res_lo = p_lo_reg;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/DIV controller: FSM, iteration counter, sign handling and hi/lo result registers.
// Define MULDIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             op_div_reg;
    logic             accept;
    logic [WIDTH-1:0] core_a, core_b;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    assign accept = (state_reg == IDLE) && start && is_muldiv_op(alucontrol);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_div_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg    <= CW'(WIDTH - 1);
                op_div_reg <= (alucontrol == ALU_DIV);
            end else if (state_reg == BUSY && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

`ifdef MULDIV_SIGNED_EN
    logic neg_q_reg, neg_r_reg;

    assign core_a = srca[WIDTH-1] ? -srca : srca;
    assign core_b = srcb[WIDTH-1] ? -srcb : srcb;

    // Divide by zero keeps the all-ones quotient unsigned so lo reads all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= (srca[WIDTH-1] ^ srcb[WIDTH-1]) &&
                         !((alucontrol == ALU_DIV) && (srcb == '0));
            neg_r_reg <= srca[WIDTH-1];
        end
    end

    always_comb begin
        fix_hi = core_hi;
        fix_lo = core_lo;
        if (op_div_reg) begin
            if (neg_q_reg) fix_lo = -core_lo;
            if (neg_r_reg) fix_hi = -core_hi;
        end else if (neg_q_reg) begin
            {fix_hi, fix_lo} = -{core_hi, core_lo};
        end
    end
`else
    assign core_a = srca;
    assign core_b = srcb;
    assign fix_hi = core_hi;
    assign fix_lo = core_lo;
`endif

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state_reg == BUSY),
        .op_div (op_div_reg),
        .a      (core_a),
        .b      (core_b),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == DONE) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
        end
    end

    // Results are visible during the DONE cycle itself and held in hi_reg/lo_reg afterwards.
    assign hi    = (state_reg == DONE) ? fix_hi : hi_reg;
    assign lo    = (state_reg == DONE) ? fix_lo : lo_reg;
    assign done  = (state_reg == DONE);
    assign busy  = (state_reg == BUSY) || (state_reg == DONE);
    assign stall = (state_reg == BUSY) || accept;

endmodule
